// File: rtl/melody_sequencer.sv
// Melody sequencer: walks an external song ROM one step at a time, holds each note for
// its programmed number of beats and drives the note index plus an articulated gate.
module melody_sequencer #(
    parameter int BEAT_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 1_250_000,
    parameter int ADDR_W      = 8,
    parameter int MUTE_CODE   = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pause,
    input  logic              stop,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [3:0]        note_sel,
    output logic              gate,
    output logic              step_tick,
    output logic              busy,
    output logic              done
);

    localparam int                CNT_W     = $clog2(8 * BEAT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  BEAT_CNT  = CNT_W'(BEAT_CYCLES);
    localparam logic [CNT_W-1:0]  GAP_CNT   = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]        MUTE_NOTE = 4'(MUTE_CODE);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PLAY,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [3:0]          note_sel_q, note_sel_d;
    logic [CNT_W-1:0]    note_cnt_q, note_cnt_d;
    logic                last_q, last_d;
    logic                gate_q, gate_d;
    logic                step_tick_q, step_tick_d;

    logic [2:0]          rom_dur;
    logic [3:0]          dur_beats;
    logic [CNT_W-1:0]    load_cnt;
    logic                song_end;

    // A zero duration field encodes the longest note (8 beats).
    assign rom_dur   = rom_data[6:4];
    assign dur_beats = (rom_dur == 3'd0) ? 4'd8 : {1'b0, rom_dur};
    assign load_cnt  = CNT_W'(dur_beats) * BEAT_CNT;
    assign song_end  = last_q || (rom_addr_q == LAST_ADDR);

    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        note_sel_d  = note_sel_q;
        note_cnt_d  = note_cnt_q;
        last_d      = last_q;
        step_tick_d = 1'b0;

        if (stop) begin
            state_d    = IDLE;
            rom_addr_d = '0;
            note_sel_d = MUTE_NOTE;
            note_cnt_d = '0;
            last_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d    = FETCH;
                        rom_addr_d = '0;
                    end
                end
                FETCH: begin
                    note_sel_d  = rom_data[3:0];
                    last_d      = rom_data[7];
                    note_cnt_d  = load_cnt;
                    step_tick_d = 1'b1;
                    state_d     = PLAY;
                end
                PLAY: begin
                    if (!pause) begin
                        if (note_cnt_q == CNT_ONE) begin
                            note_cnt_d = '0;
                            if (!song_end) begin
                                rom_addr_d = rom_addr_q + ADDR_ONE;
                                state_d    = FETCH;
                            end else if (loop_en) begin
                                rom_addr_d = '0;
                                state_d    = FETCH;
                            end else begin
                                note_sel_d = MUTE_NOTE;
                                state_d    = DONE;
                            end
                        end else begin
                            note_cnt_d = note_cnt_q - CNT_ONE;
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        state_d    = FETCH;
                        rom_addr_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Pause cannot hold FETCH, so the first PLAY cycle's gate ignores it.
        gate_d = (state_d == PLAY) && (note_cnt_d > GAP_CNT) &&
                 (note_sel_d != MUTE_NOTE) && ((state_q == FETCH) || !pause);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rom_addr_q  <= '0;
            note_sel_q  <= MUTE_NOTE;
            note_cnt_q  <= '0;
            last_q      <= 1'b0;
            gate_q      <= 1'b0;
            step_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            note_sel_q  <= note_sel_d;
            note_cnt_q  <= note_cnt_d;
            last_q      <= last_d;
            gate_q      <= gate_d;
            step_tick_q <= step_tick_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign note_sel  = note_sel_q;
    assign gate      = gate_q;
    assign step_tick = step_tick_q;
    assign busy      = (state_q == FETCH) || (state_q == PLAY);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer: song runs push expected steps, a monitor
// pops them on every step_tick and checks address, note, step length and gate time.
module tb_melody_sequencer;

    localparam int BEAT = 4;
    localparam int GAP  = 1;
    localparam int AW   = 4;
    localparam int MUTE = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic          stop = 1'b0;
    logic          loop_en = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic [3:0]    note_sel;
    logic          gate;
    logic          step_tick;
    logic          busy;
    logic          done;

    logic [7:0]    rom_mem [16];
    assign rom_data = rom_mem[rom_addr];

    typedef struct {
        int addr;
        int note;
        int play_len;
        int gate_hi;
    } step_t;

    step_t exp_q[$];
    step_t cur;
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;
    bit    in_step = 1'b0;
    int    cycles = 0;
    int    gate_hi = 0;

    melody_sequencer #(
        .BEAT_CYCLES(BEAT),
        .GAP_CYCLES (GAP),
        .ADDR_W     (AW),
        .MUTE_CODE  (MUTE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .pause    (pause),
        .stop     (stop),
        .loop_en  (loop_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .note_sel (note_sel),
        .gate     (gate),
        .step_tick(step_tick),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic report_timeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=timeout expected=event", name);
    endtask

    // Monitor: a step spans from its tick to the next tick (minus the FETCH cycle) or to done.
    always @(negedge clk) begin
        if (!mon_en) begin
            in_step = 1'b0;
        end else begin
            if (step_tick) begin
                if (in_step) begin
                    checkOutput("step_len", cycles - 1, cur.play_len);
                    checkOutput("gate_cycles", gate_hi, cur.gate_hi);
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_step actual=addr%0d expected=none", rom_addr);
                    in_step = 1'b0;
                end else begin
                    cur = exp_q.pop_front();
                    checkOutput("step_addr", int'(rom_addr), cur.addr);
                    checkOutput("step_note", int'(note_sel), cur.note);
                    in_step = 1'b1;
                    cycles  = 1;
                    gate_hi = int'(gate);
                end
            end else if (in_step) begin
                if (done) begin
                    checkOutput("step_len", cycles, cur.play_len);
                    checkOutput("gate_cycles", gate_hi, cur.gate_hi);
                    in_step = 1'b0;
                end else begin
                    cycles++;
                    gate_hi += int'(gate);
                end
            end
            if (done || note_sel == 4'(MUTE)) checkOutput("mute_gate", int'(gate), 0);
        end
    end

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (step_tick) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic abort_run();
        stop  = 1'b1;
        pause = 1'b0;
        start = 1'b0;
        @(negedge clk);
        stop   = 1'b0;
        mon_en = 1'b0;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic load_demo_rom();
        for (int a = 0; a < 16; a++) rom_mem[a] = 8'h80;
        rom_mem[0] = 8'h16;
        rom_mem[1] = 8'h25;
        rom_mem[2] = 8'h92;
    endtask

    // len==0 leaves every last flag clear so the song ends on the top address.
    task automatic randomize_rom(input int len);
        for (int a = 0; a < 16; a++) begin
            rom_mem[a] = {1'b0, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
            if ($urandom_range(0, 4) == 0) rom_mem[a][3:0] = 4'(MUTE);
        end
        if (len > 0) rom_mem[len-1][7] = 1'b1;
    endtask

    task automatic applyStimulus(input bit use_loop, input bit use_pause);
        step_t plan[$];
        int    js[$];
        int    ks[$];
        int    addr;
        int    passes;
        int    pass1_len;
        int    d;
        int    k;
        bit    ok;
        step_t s;
        logic [7:0] entry;

        addr      = 0;
        passes    = 0;
        pass1_len = 0;
        while (1) begin
            entry = rom_mem[addr];
            d = int'(entry[6:4]);
            if (d == 0) d = 8;
            k = use_pause ? $urandom_range(0, 4) : 0;
            s.addr     = addr;
            s.note     = int'(entry[3:0]);
            s.play_len = d * BEAT + k;
            s.gate_hi  = (s.note == MUTE) ? 0 : d * BEAT - GAP;
            plan.push_back(s);
            ks.push_back(k);
            js.push_back($urandom_range(0, d * BEAT - 1));
            if (entry[7] || addr == 15) begin
                passes++;
                if (passes == 1) pass1_len = plan.size();
                if (passes == (use_loop ? 2 : 1)) break;
                addr = 0;
            end else begin
                addr++;
            end
        end

        foreach (plan[i]) exp_q.push_back(plan[i]);
        loop_en = use_loop;
        mon_en  = 1'b1;
        @(negedge clk);
        pulse_start();

        for (int i = 0; i < plan.size(); i++) begin
            wait_tick(ok);
            if (!ok) begin
                report_timeout("step_tick_wait");
                abort_run();
                return;
            end
            if (use_loop && i == pass1_len) loop_en = 1'b0;
            repeat (js[i]) @(negedge clk);
            if (ks[i] > 0) begin
                pause = 1'b1;
                start = 1'($urandom_range(0, 1));
                for (int c = 0; c < ks[i]; c++) begin
                    @(negedge clk);
                    start = 1'b0;
                    checkOutput("pause_gate", int'(gate), 0);
                end
                pause = 1'b0;
            end
        end

        wait_done(ok);
        if (!ok) begin
            report_timeout("done_wait");
            abort_run();
            return;
        end
        checkOutput("done_flag", int'(done), 1);
        checkOutput("done_busy", int'(busy), 0);
        checkOutput("done_gate", int'(gate), 0);
        checkOutput("done_note", int'(note_sel), MUTE);
        @(negedge clk);
        checkOutput("scoreboard_left", exp_q.size(), 0);
        mon_en = 1'b0;
        loop_en = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_addr"}, int'(rom_addr), 0);
        checkOutput({tag, "_note"}, int'(note_sel), MUTE);
        checkOutput({tag, "_gate"}, int'(gate), 0);
        checkOutput({tag, "_tick"}, int'(step_tick), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_done"}, int'(done), 0);
    endtask

    task automatic stop_test();
        bit ok;
        mon_en = 1'b0;
        load_demo_rom();
        @(negedge clk);
        pulse_start();
        wait_tick(ok);
        if (ok) wait_tick(ok);
        if (!ok) begin
            report_timeout("stop_test_tick");
            abort_run();
            return;
        end
        checkOutput("stop_pre_addr", int'(rom_addr), 1);
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_start_addr", int'(rom_addr), 1);
        checkOutput("busy_start_busy", int'(busy), 1);
        stop  = 1'b1;
        pause = 1'b1;
        @(negedge clk);
        stop  = 1'b0;
        pause = 1'b0;
        check_reset_values("stop");
        repeat (3) @(negedge clk);
        checkOutput("stop_stays_idle", int'(busy), 0);
    endtask

    task automatic reset_test();
        bit ok;
        mon_en = 1'b0;
        load_demo_rom();
        @(negedge clk);
        pulse_start();
        wait_tick(ok);
        if (ok) wait_tick(ok);
        if (!ok) begin
            report_timeout("reset_test_tick");
            abort_run();
            return;
        end
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        for (int a = 0; a < 16; a++) rom_mem[a] = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        load_demo_rom();
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);

        for (int a = 0; a < 16; a++) rom_mem[a] = 8'h80;
        rom_mem[0] = 8'h2B;
        rom_mem[1] = 8'h97;
        applyStimulus(1'b0, 1'b1);

        load_demo_rom();
        applyStimulus(1'b0, 1'b1);

        for (int r = 0; r < 6; r++) begin
            randomize_rom($urandom_range(1, 6));
            applyStimulus(1'($urandom_range(0, 1)), 1'b1);
        end

        randomize_rom(0);
        applyStimulus(1'b0, 1'b1);

        stop_test();
        reset_test();
        load_demo_rom();
        applyStimulus(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
